// File: rtl/dc_router_pkg.sv
// Shared constants and encodings for the data & control router and its accelerator FIFOs.
package dc_router_pkg;

    localparam int DC_DATA_WIDTH = 32;
    localparam int DC_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        DC_ACC_NONE = 2'd0,
        DC_ACC_FFT  = 2'd1,
        DC_ACC_FIR  = 2'd2,
        DC_ACC_IIR  = 2'd3
    } dc_acc_sel_e;

    // Flow direction of a FIFO instance relative to the accelerator.
    typedef enum logic {
        DC_DIR_TO_ACC   = 1'b0,
        DC_DIR_FROM_ACC = 1'b1
    } dc_fifo_dir_e;

endpackage

// File: rtl/dc_fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and one registered read port.
// Kept separate so it can be replaced by a memory macro without touching the control logic.
module dc_fifo_mem
    import dc_router_pkg::*;
#(
    parameter int WIDTH = DC_DATA_WIDTH,
    parameter int DEPTH = DC_FIFO_DEPTH,
    parameter int AW    = $clog2(DC_FIFO_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Write port; array contents are deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read register holds the last popped word until the next read.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= r_rd_data;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dc_acc_fifo.sv
// Single-clock router<->accelerator sample FIFO with registered flags and error pulses.
// Optional occupancy port `count` is built when DC_FIFO_COUNT_EN is defined.
module dc_acc_fifo
    import dc_router_pkg::*;
#(
    parameter int WIDTH = DC_DATA_WIDTH,
    parameter int DEPTH = DC_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             put_req,
    input  logic [WIDTH-1:0] data_in,
    input  logic             get_req,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
`ifdef DC_FIFO_COUNT_EN
    ,
    output logic [AW:0]      count
`endif
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_out_valid;
    logic        r_overflow;
    logic        r_underflow;

    logic        w_full;
    logic        w_empty;
    logic        w_put_acc;
    logic        w_get_acc;

    // The extra MSB distinguishes a full ring from an empty one when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // Accepts use the pre-edge flags, so a same-cycle put/get never hits one address.
    assign w_put_acc = put_req && !w_full  && !reset;
    assign w_get_acc = get_req && !w_empty && !reset;

    dc_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wr_en   (w_put_acc),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (data_in),
        .i_rd_en   (w_get_acc),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (data_out)
    );

    // Write pointer advances on every accepted put.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
        end else if (w_put_acc) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end else begin
            r_wr_ptr <= r_wr_ptr;
        end
    end

    // Read pointer advances on every accepted get.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
        end else if (w_get_acc) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end else begin
            r_rd_ptr <= r_rd_ptr;
        end
    end

    // Single-cycle status: read valid and rejected-request pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_out_valid <= w_get_acc;
            r_overflow  <= put_req && w_full;
            r_underflow <= get_req && w_empty;
        end
    end

    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign full      = w_full;
    assign empty     = w_empty;

`ifdef DC_FIFO_COUNT_EN
    logic [AW:0] r_count;

    // Occupancy moves on the same edge as the pointers and always equals wr_ptr - rd_ptr.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_put_acc, w_get_acc})
                2'b10:   r_count <= r_count + PTR_ONE;
                2'b01:   r_count <= r_count - PTR_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
`endif

endmodule

// File: tb/tb_dc_acc_fifo.sv
// Self-checking bench for dc_acc_fifo: queue-based reference model plus directed and random stimulus.
// Checks `count` as well when DC_FIFO_COUNT_EN is defined.
module tb_dc_acc_fifo;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        put_req;
    logic        get_req;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        out_valid;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        underflow;
`ifdef DC_FIFO_COUNT_EN
    logic [4:0]  count;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] q[$];
    logic [31:0] m_dout;
    bit          m_valid;
    bit          m_ovf;
    bit          m_unf;

    always #5 clk = ~clk;

    dc_acc_fifo #(.WIDTH(32), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .put_req   (put_req),
        .data_in   (data_in),
        .get_req   (get_req),
        .data_out  (data_out),
        .out_valid (out_valid),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef DC_FIFO_COUNT_EN
        ,
        .count     (count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: what the edge about to happen must produce.
    task automatic model_step(input bit p, input logic [31:0] d, input bit g, input bit r);
        int n;
        n = q.size();
        if (r) begin
            q.delete();
            m_dout  = 32'd0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            if (g) begin
                if (n == 0) m_unf = 1'b1;
                else begin
                    m_dout  = q.pop_front();
                    m_valid = 1'b1;
                end
            end
            if (p) begin
                if (n == D) m_ovf = 1'b1;
                else q.push_back(d);
            end
        end
    endtask

    task automatic check_model();
        chk("empty",     32'(empty),     32'(q.size() == 0));
        chk("full",      32'(full),      32'(q.size() == D));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("data_out",  data_out,       m_dout);
`ifdef DC_FIFO_COUNT_EN
        chk("count",     32'(count),     32'(q.size()));
`endif
    endtask

    task automatic cycle(input bit p, input logic [31:0] d, input bit g, input bit r);
        reset   = r;
        put_req = p;
        data_in = d;
        get_req = g;
        model_step(p, d, g, r);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic chk_count(input string name, input int exp);
`ifdef DC_FIFO_COUNT_EN
        chk(name, 32'(count), 32'(exp));
`else
        chk(name, 32'(full), 32'(exp == D));
`endif
    endtask

    initial begin
        bit seen99;
        int put_pct;
        int get_pct;

        reset = 1'b1; put_req = 1'b0; get_req = 1'b0; data_in = 32'd0;
        m_dout = 32'd0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", data_out, 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        cycle(1'b0, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) cycle(1'b1, 32'(122 + i), 1'b0, 1'b0);
        chk("seq_not_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'd0, 1'b1, 1'b0);
            chk("seq_dout", data_out, 32'(122 + i));
            chk("seq_valid", 32'(out_valid), 32'd1);
        end
        chk("seq_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 16; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        cycle(1'b1, 32'd99, 1'b0, 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
        chk("ovf_once", 32'(overflow), 32'd0);
        seen99 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 32'd0, 1'b1, 1'b0);
            chk("drain_dout", data_out, 32'(i));
            if (data_out == 32'd99) seen99 = 1'b1;
        end
        chk("no_99", 32'(seen99), 32'd0);

        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("unf_pulse", 32'(underflow), 32'd1);
        chk("unf_valid", 32'(out_valid), 32'd0);
        chk("unf_hold", data_out, 32'd15);
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
        chk("unf_once", 32'(underflow), 32'd0);

        for (int i = 0; i < 8; i++) cycle(1'b1, 32'(1000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 32'(1008 + i), 1'b1, 1'b0);
            chk("wrap_dout", data_out, 32'(1000 + i));
        end
        chk_count("wrap_count8", 8);
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'(1048 + i), 1'b0, 1'b0);
        chk("wrap_full", 32'(full), 32'd1);
        cycle(1'b1, 32'd77, 1'b1, 1'b0);
        chk("full_rw_ovf", 32'(overflow), 32'd1);
        chk("full_rw_dout", data_out, 32'd1040);
        chk_count("full_rw_count", 15);
        for (int i = 0; i < 15; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("drained_empty", 32'(empty), 32'd1);
        chk("drained_last", data_out, 32'd1055);
        cycle(1'b1, 32'd88, 1'b1, 1'b0);
        chk("empty_rw_unf", 32'(underflow), 32'd1);
        chk("empty_rw_not_empty", 32'(empty), 32'd0);
        chk_count("empty_rw_count", 1);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("empty_rw_dout", data_out, 32'd88);

        for (int i = 0; i < 5; i++) cycle(1'b1, 32'(500 + i), 1'b0, 1'b0);
        cycle(1'b1, 32'd55, 1'b0, 1'b1);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_dout", data_out, 32'd0);
        chk_count("midrst_count", 0);
        cycle(1'b1, 32'hABCD_0001, 1'b0, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("midrst_new", data_out, 32'hABCD_0001);
        chk("midrst_drained", 32'(empty), 32'd1);

        for (int ph = 0; ph < 8; ph++) begin
            put_pct = (ph % 2 == 0) ? 80 : 25;
            get_pct = (ph % 2 == 0) ? 30 : 75;
            for (int c = 0; c < 300; c++) begin
                cycle(($urandom_range(0, 99) < put_pct), $urandom,
                      ($urandom_range(0, 99) < get_pct), ($urandom_range(0, 199) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dc_acc_fifo.md
# dc_acc_fifo

Single-clock synchronous FIFO that buffers 32-bit samples between the data & control router and one accelerator (FFT, FIR or IIR). It is the responder for the router's `*_put_req`/`*_get_req` handshake and drives the `full`/`empty` flags the router polls. Each accelerator uses two instances:
- a "to" FIFO: router writes, accelerator reads.
- a "from" FIFO: accelerator writes, router reads.

## Interface
Parameters:
- `WIDTH`, 32, data word width in bits.
- `DEPTH`, 16, number of entries; must be a power of 2, minimum 2.
- `AW`, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `put_req` in 1: write strobe; one word per cycle while high.
- `data_in` in WIDTH: write data, sampled with `put_req`.
- `get_req` in 1: read strobe; one word per cycle while high.
- `data_out` out WIDTH: read data, registered.
- `out_valid` out 1: `data_out` holds a word popped on the previous cycle.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `overflow` out 1: one-cycle pulse, put rejected.
- `underflow` out 1: one-cycle pulse, get rejected.
- `count` out AW+1: occupancy; present only with `DC_FIFO_COUNT_EN`.

## Operation
- Storage is DEPTH x WIDTH. Pointers `wr_ptr` and `rd_ptr` are AW+1 bits: the MSB is a wrap bit, the low AW bits index storage.
- Flags:
  - `empty` = pointers equal.
  - `full` = low bits equal and MSBs differ.
  - Both flags are computed from registered pointers; no combinational path from `put_req`/`get_req`.
- Put accept = `put_req & ~full` at the clock edge. Write `data_in` to `mem[wr_ptr[AW-1:0]]`; increment `wr_ptr` modulo 2^(AW+1).
- Get accept = `get_req & ~empty`. Load `data_out` from `mem[rd_ptr[AW-1:0]]`; increment `rd_ptr`; set `out_valid` for exactly the next cycle.
- Rejected put (`put_req & full`):
  - no state change; data dropped.
  - `overflow` = 1 next cycle.
- Rejected get (`get_req & empty`):
  - `data_out` holds its previous value.
  - `out_valid` = 0.
  - `underflow` = 1 next cycle.
- Flags use the pre-edge state. Consequences:
  - Put and get together while full: get accepted, put rejected (overflow pulses); count becomes DEPTH-1.
  - Put and get together while empty: put accepted, get rejected (underflow pulses); no write-to-read bypass.
  - Put and get together otherwise: both accepted; count unchanged.
- `data_out` holds its last popped value until the next accepted get.
- Reset:
  - Pointers = 0, `data_out` = 0, `out_valid` = 0, `overflow` = 0, `underflow` = 0, `empty` = 1, `full` = 0, `count` = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words. It takes priority over simultaneous put/get.

## Timing
- Write-to-flag latency is 1 cycle: `empty` falls on the edge after the first accepted put.
- Read latency is 1 cycle: `data_out`/`out_valid` are valid the cycle after `get_req` is sampled.
- Throughput: one put and one get per cycle, sustained.
- First-word fall-through: none.
- `full` rises on the edge that accepts the DEPTH-th word. `empty` rises on the edge that accepts the last get.
- All outputs are registered or are pure functions of registers.

## Configuration
- `DC_FIFO_COUNT_EN` defined:
  - `count` port exists.
  - Registered occupancy `wr_ptr - rd_ptr` (AW+1 bits), range 0..DEPTH.
  - Updated on the same edge as the pointers.
- `DC_FIFO_COUNT_EN` undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package `dc_router_pkg` holds:
  - `DC_DATA_WIDTH` = 32.
  - `DC_FIFO_DEPTH` = 16.
  - The accelerator select encodings used by the router.
- Sub-module `dc_fifo_mem`:
  - Plain DEPTH x WIDTH register array.
  - One synchronous write port; one synchronous read port with registered output.
  - Isolated so it can later be swapped for a memory macro.
- Pointer, flag and error logic stay in `dc_acc_fifo`.

## Test plan
- Reset → `empty`=1, `full`=0, `out_valid`=0, `data_out`=0, `overflow`=0, `underflow`=0 on the first cycle after reset deasserts.
- Put 122, 123, 124 on consecutive cycles, then three gets → `data_out` = 122, 123, 124 on the three cycles after each get; `out_valid`=1 each cycle; `empty`=1 after the third get.
- Put words 0..15 → `full`=1 after the 16th; a 17th put of 99 → `overflow` pulses once; 16 gets return 0..15 and 99 never appears.
- Empty FIFO, `get_req`=1 → `underflow`=1 for one cycle; `out_valid`=0; `data_out` unchanged.
- Wrap and simultaneous access:
  - Fill to 8, then 40 cycles of simultaneous put/get with incrementing data.
  - Occupancy stays 8 and output is in strict order across pointer wrap.
  - Full + simultaneous put/get → count 15 and `overflow` pulses.
  - Empty + simultaneous put/get → count 1 and `underflow` pulses.
- Reset asserted with 5 words stored and `put_req`=1 → `empty`=1 next cycle; a later get returns only newly written data. With `DC_FIFO_COUNT_EN`, `count` tracks 0..16 throughout.
